// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle triggers into fixed-width high levels,
// each followed by a guaranteed low gap. Triggers that arrive while a pulse
// is running are counted and replayed in order. If too many arrive, the extra
// ones are dropped and a sticky overflow flag is set.
//
// Optional feature: define PULSE_STRETCHER_RETRIGGER_EN so that a trigger
// during the high interval extends the current pulse instead of queueing.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no pulse in progress, nothing queued
// HIGH  | out=1, cnt counts down the remaining high cycles
// GAP   | out=0, cnt counts down the remaining low-gap cycles
module pulse_stretcher #(
   parameter int WIDTH_BITS = 8,
   parameter int QUEUE_BITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in,
   input  logic [WIDTH_BITS-1:0] width,
   input  logic [WIDTH_BITS-1:0] gap,
   output logic                  out,
   output logic                  busy,
   output logic [QUEUE_BITS-1:0] pending,
   output logic                  overflow
);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
   localparam bit RETRIGGER_EN = 1'b1;
`else
   localparam bit RETRIGGER_EN = 1'b0;
`endif

   localparam logic [QUEUE_BITS-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

   state_t                state;
   logic [WIDTH_BITS-1:0] cnt;
   logic [WIDTH_BITS-1:0] width_m1;
   logic [WIDTH_BITS-1:0] gap_m1;
   logic                  pend_full;

   // Zero-length settings are treated as one cycle.
   always_comb begin
      width_m1  = (width == '0) ? '0 : width - WIDTH_BITS'(1);
      gap_m1    = (gap == '0) ? '0 : gap - WIDTH_BITS'(1);
      pend_full = (pending == PEND_MAX);
   end

   // Sequencer: state, interval counter, pending queue and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         out      <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in) begin
                  state <= S_HIGH;
                  cnt   <= width_m1;
                  out   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            S_HIGH: begin
               if (in && RETRIGGER_EN) begin
                  cnt <= width_m1;
               end else begin
                  if (in) begin
                     if (!pend_full) pending <= pending + QUEUE_BITS'(1);
                     else            overflow <= 1'b1;
                  end
                  if (cnt == '0) begin
                     state <= S_GAP;
                     cnt   <= gap_m1;
                     out   <= 1'b0;
                  end else begin
                     cnt <= cnt - WIDTH_BITS'(1);
                  end
               end
            end
            S_GAP: begin
               if (cnt == '0) begin
                  if (pending != '0) begin
                     // A trigger on the dequeue cycle cancels the decrement.
                     state <= S_HIGH;
                     cnt   <= width_m1;
                     out   <= 1'b1;
                     if (!in) pending <= pending - QUEUE_BITS'(1);
                  end else if (in) begin
                     state <= S_HIGH;
                     cnt   <= width_m1;
                     out   <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - WIDTH_BITS'(1);
                  if (in) begin
                     if (!pend_full) pending <= pending + QUEUE_BITS'(1);
                     else            overflow <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
               out   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: a schedule-based model (list of pulse start
// times and lengths) checked against the DUT every cycle, plus literal
// expectations per directed scenario.
module tb_pulse_stretcher;

   localparam int WB   = 8;
   localparam int QB   = 3;
   localparam int PMAX = (1 << QB) - 1;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          in;
   logic [WB-1:0] width;
   logic [WB-1:0] gap;
   logic          out;
   logic          busy;
   logic [QB-1:0] pending;
   logic          overflow;

   pulse_stretcher #(.WIDTH_BITS(WB), .QUEUE_BITS(QB)) dut (
      .clk(clk), .reset(reset), .in(in), .width(width), .gap(gap),
      .out(out), .busy(busy), .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: scheduled pulses as (start edge, high length, gap length)
   int ms[$];
   int mw[$];
   int mg[$];
   int  e = 0;
   bit  armed = 0;
   bit  m_ovf = 0;
   bit  x_out, x_busy;
   int  x_pend;

   // observed statistics for literal checks
   int  st_high, st_busy, st_rise, st_peak;
   bit  prev_out;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, e, act, exp);
      end
   endtask

   always @(posedge clk) begin : model
      int free, cnt, d, weff, geff, st;
      weff = (width == 0) ? 1 : int'(width);
      geff = (gap == 0) ? 1 : int'(gap);
      if (reset) begin
         ms.delete(); mw.delete(); mg.delete();
         m_ovf = 0;
         armed = 1;
      end else begin
         while (ms.size() > 0 && ms[0] + mw[0] + mg[0] <= e) begin
            void'(ms.pop_front()); void'(mw.pop_front()); void'(mg.pop_front());
         end
         if (in) begin
            if (RETRIG && ms.size() > 0 && ms[0] <= e - 1 && e - 1 < ms[0] + mw[0]) begin
               d = e + weff - (ms[0] + mw[0]);
               mw[0] += d;
               for (int i = 1; i < ms.size(); i++) ms[i] += d;
            end else begin
               cnt = 0;
               foreach (ms[i]) if (ms[i] > e) cnt++;
               if (cnt < PMAX) begin
                  free = (ms.size() > 0) ? ms[$] + mw[$] + mg[$] : e;
                  st = (free > e) ? free : e;
                  ms.push_back(st); mw.push_back(weff); mg.push_back(geff);
               end else begin
                  m_ovf = 1;
               end
            end
         end
      end
      x_out = 0; x_busy = 0; x_pend = 0;
      foreach (ms[i]) begin
         if (ms[i] <= e && e < ms[i] + mw[i]) x_out = 1;
         if (ms[i] <= e && e < ms[i] + mw[i] + mg[i]) x_busy = 1;
         if (ms[i] > e) x_pend++;
      end
      e++;
   end

   // every-cycle comparison plus statistics for the directed scenarios
   always @(negedge clk) begin
      if (armed) begin
         check("out", int'(out), int'(x_out));
         check("busy", int'(busy), int'(x_busy));
         check("pending", int'(pending), x_pend);
         check("overflow", int'(overflow), int'(m_ovf));
         if (out) st_high++;
         if (busy) st_busy++;
         if (out && !prev_out) st_rise++;
         if (int'(pending) > st_peak) st_peak = int'(pending);
         prev_out = out;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      st_high = 0; st_busy = 0; st_rise = 0; st_peak = 0;
   endtask

   task automatic trig();
      in = 1'b1; cyc(1); in = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (!busy && pending == '0) break;
         cyc(1);
      end
      if (i == budget) begin
         errors++;
         $display("FAIL wait_idle timeout after %0d cycles busy=%0d expected 0", budget, busy);
      end
      cyc(2);
   endtask

   initial begin
      reset = 1'b1; in = 1'b0; width = 8'd4; gap = 8'd2;
      prev_out = 0;
      clear_stats();
      cyc(3);
      check("reset_out", int'(out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_pending", int'(pending), 0);
      check("reset_overflow", int'(overflow), 0);
      reset = 1'b0;
      cyc(5);

      // single pulse, width 4 gap 2
      clear_stats();
      trig();
      wait_idle(50);
      check("s1_high_cycles", st_high, 4);
      check("s1_busy_cycles", st_busy, 6);

`ifndef PULSE_STRETCHER_RETRIGGER_EN
      // three back-to-back triggers replay as three pulses
      width = 8'd3; gap = 8'd2; clear_stats();
      in = 1'b1; cyc(3); in = 1'b0;
      wait_idle(60);
      check("s2_rises", st_rise, 3);
      check("s2_high_cycles", st_high, 9);
      check("s2_peak_pending", st_peak, 2);
      check("s2_overflow", int'(overflow), 0);

      // zero width/gap behave as one
      width = 8'd0; gap = 8'd0; clear_stats();
      in = 1'b1; cyc(2); in = 1'b0;
      wait_idle(30);
      check("s3_rises", st_rise, 2);
      check("s3_high_cycles", st_high, 2);
      check("s3_busy_cycles", st_busy, 4);

      // queue saturation: 1 start + 9 triggers during HIGH
      width = 8'd20; gap = 8'd1; clear_stats();
      in = 1'b1; cyc(10); in = 1'b0;
      wait_idle(400);
      check("s4_rises", st_rise, 8);
      check("s4_peak_pending", st_peak, 7);
      check("s4_overflow_sticky", int'(overflow), 1);
`endif

      // reset on the third high cycle, trigger held during reset is ignored
      width = 8'd8; gap = 8'd2;
      trig();
      cyc(2);
      reset = 1'b1; in = 1'b1; cyc(1); reset = 1'b0; in = 1'b0;
      check("s5_out", int'(out), 0);
      check("s5_busy", int'(busy), 0);
      check("s5_pending", int'(pending), 0);
      check("s5_overflow", int'(overflow), 0);
      clear_stats();
      cyc(2);
      trig();
      wait_idle(50);
      check("s5_high_cycles", st_high, 8);

      // width change mid-pulse does not affect the running interval
      width = 8'd5; gap = 8'd3; clear_stats();
      trig();
      cyc(2);
      width = 8'd2;
      wait_idle(50);
      check("s6_high_cycles", st_high, 5);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
      // retrigger extends instead of queueing
      width = 8'd4; gap = 8'd2; clear_stats();
      trig();
      cyc(1);
      trig();
      wait_idle(50);
      check("rt_high_cycles", st_high, 6);
      check("rt_rises", st_rise, 1);
      check("rt_peak_pending", st_peak, 0);
`endif

      // random trigger traffic against the model
      width = 8'd3; gap = 8'd1;
      for (int i = 0; i < 200; i++) begin
         in = ($urandom_range(0, 3) == 0);
         cyc(1);
      end
      in = 1'b0;
      wait_idle(400);
      width = 8'd1; gap = 8'd2;
      for (int i = 0; i < 200; i++) begin
         in = ($urandom_range(0, 1) == 0);
         cyc(1);
      end
      in = 1'b0;
      wait_idle(400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
